// File: rtl/baud_pkg.sv
// Shared rate codes, FSM states and timing defaults for the
// baud-rate configuration arbiter.
package baud_pkg;

    localparam logic [1:0] BAUD24  = 2'b00;
    localparam logic [1:0] BAUD48  = 2'b01;
    localparam logic [1:0] BAUD96  = 2'b10;
    localparam logic [1:0] BAUD192 = 2'b11;

    localparam int unsigned HOLD_DEF   = 2;
    localparam int unsigned SETTLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        APPLY,
        SETTLE,
        ACK
    } state_t;

endpackage

// File: rtl/baud_cfg_arbiter_rr_arb2.sv
// Two-requester round-robin grant: ptr breaks ties when both
// requesters are valid.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant
);

    assign grant = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/baud_cfg_arbiter.sv
// Serialises rate-change requests from two requesters, restarts the baud
// generator when the link is idle and acknowledges once it has settled.
module baud_cfg_arbiter
    import baud_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = HOLD_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_DEF,
    parameter logic [1:0]  DEFAULT_RATE  = BAUD96
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_rate,
    output logic [1:0] req_ready,
    input  logic       link_busy,
    output logic [1:0] baud_rate,
    output logic       gen_reset_n,
    output logic       cfg_active
);

    state_t     r_state;
    logic       r_rr_ptr;
    logic       r_gnt_idx;
    logic [1:0] r_rate;
    logic [7:0] r_hold_cnt;
    logic [7:0] r_settle_cnt;
    logic [1:0] r_baud;
    logic       r_gen_rst_n;
    logic [1:0] r_ready;
    logic       r_active;

    logic       w_gnt;
    logic [1:0] w_sel_rate;
    logic [1:0] w_gnt_onehot;
    logic [1:0] w_lat_onehot;

    rr_arb2 u_arb (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_gnt)
    );

    assign w_sel_rate   = w_gnt ? req_rate[3:2] : req_rate[1:0];
    assign w_gnt_onehot = w_gnt ? 2'b10 : 2'b01;
    assign w_lat_onehot = r_gnt_idx ? 2'b10 : 2'b01;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= 1'b0;
            r_gnt_idx    <= 1'b0;
            r_rate       <= DEFAULT_RATE;
            r_hold_cnt   <= 8'd0;
            r_settle_cnt <= 8'd0;
            r_baud       <= DEFAULT_RATE;
            r_gen_rst_n  <= 1'b0;
            r_ready      <= 2'b00;
            r_active     <= 1'b0;
        end else begin
            r_ready <= 2'b00;
            unique case (r_state)
                IDLE: begin
                    r_gen_rst_n <= 1'b1;
                    if (|req_valid) begin
                        r_gnt_idx <= w_gnt;
                        r_rate    <= w_sel_rate;
                        r_active  <= 1'b1;
                        // Same rate: acknowledge without disturbing the generator
                        if (w_sel_rate == r_baud) begin
                            r_state <= ACK;
                            r_ready <= w_gnt_onehot;
                        end else begin
                            r_state <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (!link_busy) begin
                        r_state     <= APPLY;
                        r_baud      <= r_rate;
                        r_gen_rst_n <= 1'b0;
                        r_hold_cnt  <= 8'(HOLD_CYCLES - 1);
                    end
                end
                APPLY: begin
                    if (r_hold_cnt == 8'd0) begin
                        r_state      <= SETTLE;
                        r_gen_rst_n  <= 1'b1;
                        r_settle_cnt <= 8'(SETTLE_CYCLES - 1);
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == 8'd0) begin
                        r_state <= ACK;
                        r_ready <= w_lat_onehot;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                ACK: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                    r_rr_ptr <= ~r_gnt_idx;
                end
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_ready;
    assign baud_rate   = r_baud;
    assign gen_reset_n = r_gen_rst_n;
    assign cfg_active  = r_active;

endmodule

// File: tb/tb_baud_cfg_arbiter.sv
// Directed bench for baud_cfg_arbiter with default HOLD/SETTLE timing.
module tb_baud_cfg_arbiter;

    logic       clock;
    logic       reset_n;
    logic [1:0] req_valid;
    logic [3:0] req_rate;
    logic [1:0] req_ready;
    logic       link_busy;
    logic [1:0] baud_rate;
    logic       gen_reset_n;
    logic       cfg_active;

    int errors = 0;
    int checks = 0;

    baud_cfg_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_rate    (req_rate),
        .req_ready   (req_ready),
        .link_busy   (link_busy),
        .baud_rate   (baud_rate),
        .gen_reset_n (gen_reset_n),
        .cfg_active  (cfg_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_rate  = 4'b0000;
        link_busy = 1'b0;
        tick();
        tick();
        chk("rst_baud", 8'(baud_rate), 8'h2);
        chk("rst_gen", 8'(gen_reset_n), 8'h0);
        chk("rst_ready", 8'(req_ready), 8'h0);
        chk("rst_active", 8'(cfg_active), 8'h0);

        reset_n = 1'b1;
        tick();
        chk("rel_gen", 8'(gen_reset_n), 8'h1);
        chk("rel_active", 8'(cfg_active), 8'h0);

        // Same-rate request from requester 0
        req_valid = 2'b01;
        req_rate  = 4'b0010;
        tick();
        chk("same_ready", 8'(req_ready), 8'h1);
        chk("same_gen", 8'(gen_reset_n), 8'h1);
        chk("same_baud", 8'(baud_rate), 8'h2);
        chk("same_active", 8'(cfg_active), 8'h1);
        req_valid = 2'b00;
        tick();
        chk("same_ready_off", 8'(req_ready), 8'h0);
        chk("same_active_off", 8'(cfg_active), 8'h0);

        // Full change to rate 11, link idle
        req_valid = 2'b01;
        req_rate  = 4'b0011;
        tick();
        chk("chg_t1_active", 8'(cfg_active), 8'h1);
        chk("chg_t1_baud", 8'(baud_rate), 8'h2);
        chk("chg_t1_gen", 8'(gen_reset_n), 8'h1);
        tick();
        chk("chg_t2_baud", 8'(baud_rate), 8'h3);
        chk("chg_t2_gen", 8'(gen_reset_n), 8'h0);
        tick();
        chk("chg_t3_gen", 8'(gen_reset_n), 8'h0);
        tick();
        chk("chg_t4_gen", 8'(gen_reset_n), 8'h1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("chg_settle_ready", 8'(req_ready), 8'h0);
        end
        tick();
        chk("chg_t20_ready", 8'(req_ready), 8'h1);
        chk("chg_t20_active", 8'(cfg_active), 8'h1);
        req_valid = 2'b00;
        tick();
        chk("chg_t21_ready", 8'(req_ready), 8'h0);
        chk("chg_t21_active", 8'(cfg_active), 8'h0);

        // Requester 1 asks for rate 00 while the link is busy
        req_valid = 2'b10;
        req_rate  = 4'b0000;
        link_busy = 1'b1;
        tick();
        chk("busy_active0", 8'(cfg_active), 8'h1);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("busy_baud", 8'(baud_rate), 8'h3);
            chk("busy_gen", 8'(gen_reset_n), 8'h1);
            chk("busy_active", 8'(cfg_active), 8'h1);
        end
        link_busy = 1'b0;
        tick();
        chk("busy_apply_baud", 8'(baud_rate), 8'h0);
        chk("busy_apply_gen", 8'(gen_reset_n), 8'h0);
        link_busy = 1'b1;
        tick();
        chk("busy_hold_gen", 8'(gen_reset_n), 8'h0);
        tick();
        chk("busy_settle_gen", 8'(gen_reset_n), 8'h1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("busy_settle_ready", 8'(req_ready), 8'h0);
        end
        tick();
        chk("busy_ack_ready", 8'(req_ready), 8'h2);
        req_valid = 2'b00;
        link_busy = 1'b0;
        tick();
        chk("busy_ack_off", 8'(req_ready), 8'h0);

        // Requester 0: rate changes and valid drops after grant
        req_valid = 2'b01;
        req_rate  = 4'b0001;
        tick();
        req_valid = 2'b00;
        req_rate  = 4'b0011;
        tick();
        chk("latch_baud", 8'(baud_rate), 8'h1);
        chk("latch_gen", 8'(gen_reset_n), 8'h0);
        tick();
        tick();
        chk("latch_gen_hi", 8'(gen_reset_n), 8'h1);
        repeat (15) tick();
        tick();
        chk("latch_ready", 8'(req_ready), 8'h1);
        chk("latch_baud_keep", 8'(baud_rate), 8'h1);
        tick();
        chk("latch_ready_off", 8'(req_ready), 8'h0);

        // Reset in the middle of SETTLE
        req_valid = 2'b10;
        req_rate  = 4'b1000;
        tick();
        tick();
        chk("mid_apply_baud", 8'(baud_rate), 8'h2);
        req_rate = 4'b0000;
        tick();
        tick();
        chk("mid_settle_gen", 8'(gen_reset_n), 8'h1);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk("mid_rst_baud", 8'(baud_rate), 8'h2);
        chk("mid_rst_gen", 8'(gen_reset_n), 8'h0);
        chk("mid_rst_ready", 8'(req_ready), 8'h0);
        chk("mid_rst_active", 8'(cfg_active), 8'h0);
        reset_n   = 1'b1;
        req_valid = 2'b00;
        for (int i = 0; i < 25; i++) begin
            tick();
            chk("mid_no_ack", 8'(req_ready), 8'h0);
            chk("mid_idle", 8'(cfg_active), 8'h0);
        end

        // Both requesters valid, rr_ptr=0 after reset
        req_valid = 2'b11;
        req_rate  = 4'b1101;
        tick();
        tick();
        chk("rr0_baud", 8'(baud_rate), 8'h1);
        tick();
        tick();
        repeat (15) tick();
        tick();
        chk("rr0_ready", 8'(req_ready), 8'h1);
        req_valid = 2'b10;
        tick();
        chk("rr0_ready_off", 8'(req_ready), 8'h0);
        chk("rr0_idle", 8'(cfg_active), 8'h0);
        tick();
        chk("rr1_active", 8'(cfg_active), 8'h1);
        tick();
        chk("rr1_baud", 8'(baud_rate), 8'h3);
        chk("rr1_gen", 8'(gen_reset_n), 8'h0);
        tick();
        tick();
        repeat (15) tick();
        tick();
        chk("rr1_ready", 8'(req_ready), 8'h2);
        req_valid = 2'b00;
        tick();
        chk("rr1_ready_off", 8'(req_ready), 8'h0);

        // rr_ptr back at 0: requester 0 wins the tie (same rate, fast ack)
        req_valid = 2'b11;
        req_rate  = 4'b0011;
        tick();
        chk("rr_ptr_end", 8'(req_ready), 8'h1);
        req_valid = 2'b00;
        tick();
        chk("rr_end_idle", 8'(cfg_active), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/baud_cfg_arbiter.md
BAUD_CFG_ARBITER -- requirements
Module: baud_cfg_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, is the cycle count gen_reset_n is held low per rate change (legal 1..255).
REQ-002 Parameter SETTLE_CYCLES, default 16, is the cycle count after generator release before acknowledgement (legal 1..255).
REQ-003 Parameter DEFAULT_RATE, default 2'b10 (9600), is the rate code driven out of reset.
REQ-004 clock  in  1  system clock; the block uses one clock.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 req_valid  in  2  per-requester rate-change request; bit 0 is the host, bit 1 is the auto-config requester.
REQ-007 req_rate  in  4  requested rate codes; [1:0] belongs to requester 0 and [3:2] to requester 1.
REQ-008 req_ready  out  2  one-cycle acknowledge to the granted requester.
REQ-009 link_busy  in  1  high while a Tx or Rx frame is in progress.
REQ-010 baud_rate  out  2  rate code to the baud generator: 00=2400, 01=4800, 10=9600, 11=19200.
REQ-011 gen_reset_n  out  1  active-low restart to the baud generator's reset_n.
REQ-012 cfg_active  out  1  high while a change is in progress; it inhibits frame starts in Tx/Rx.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, WAIT_IDLE, APPLY, SETTLE and ACK; all outputs SHALL be registered.
REQ-014 In IDLE at cycle T with any req_valid set, the block SHALL grant one requester and latch its index and rate; later changes to req_rate SHALL be ignored.
REQ-015 Arbitration: with one valid requester, the block SHALL grant that requester; with both valid, it SHALL grant the requester selected by rr_ptr; after ACK, rr_ptr SHALL point to the non-granted index.
REQ-016 If the latched rate equals the current baud_rate, the FSM SHALL go IDLE->ACK and req_ready SHALL be high at T+1 with no generator restart.
REQ-017 Otherwise, the FSM SHALL enter WAIT_IDLE at T+1 and remain there while link_busy=1.
REQ-018 On the first cycle in WAIT_IDLE with link_busy=0, the FSM SHALL enter APPLY on the next edge; at that edge baud_rate SHALL take the latched rate and gen_reset_n SHALL go low.
REQ-019 gen_reset_n SHALL stay low for exactly HOLD_CYCLES cycles and then return high as the FSM enters SETTLE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles; ACK follows.
REQ-021 With link idle at T+1, latency SHALL be: baud_rate updated and gen_reset_n low at T+2; gen_reset_n high at T+2+HOLD_CYCLES; req_ready pulse at T+2+HOLD_CYCLES+SETTLE_CYCLES.
REQ-022 In ACK, only the granted bit of req_ready SHALL be high, for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-023 The earliest re-grant SHALL be the cycle after ACK, so back-to-back requests are served at one per ACK.
REQ-024 cfg_active SHALL be high exactly when state != IDLE, including the ACK cycle.
REQ-025 link_busy changes after WAIT_IDLE exits SHALL be ignored.
REQ-026 A requester dropping req_valid after grant SHALL NOT abort the change; its ack is still issued.
REQ-027 Each requester SHALL keep req_valid high until req_ready; req_valid still high in the cycle after ACK SHALL be treated as a new request.
REQ-028 The HOLD and SETTLE counters SHALL be 8-bit, load at state entry, and count down to zero.

Reset
REQ-029 While reset_n=0 at a clock edge, outputs SHALL take these values: baud_rate=DEFAULT_RATE, gen_reset_n=0, req_ready=2'b00, cfg_active=0; state SHALL be IDLE and rr_ptr=0.
REQ-030 gen_reset_n SHALL be 1 on the first edge after reset_n returns high.
REQ-031 Reset asserted mid-operation SHALL abandon the change with no req_ready, and baud_rate SHALL return to DEFAULT_RATE.

Structure
REQ-032 Package baud_pkg SHALL hold the four rate-code constants (BAUD24/48/96/192), the FSM state enumeration and the default HOLD/SETTLE values.
REQ-033 The 2-requester round-robin grant logic SHALL be the one sub-module, rr_arb2 (inputs req[1:0] and ptr; output grant index).

Verification
REQ-034 Reset, then req_valid=01, req_rate[1:0]=10 -> req_ready=01 at T+1, gen_reset_n stays 1, baud_rate stays 10.
REQ-035 req_valid=01, rate 11, link_busy=0 -> baud_rate=11 and gen_reset_n=0 at T+2..T+3; gen_reset_n=1 at T+4; req_ready=01 at T+20 (defaults).
REQ-036 Rate 00 requested with link_busy=1 for 50 cycles -> baud_rate unchanged and gen_reset_n=1 throughout; APPLY starts 1 cycle after link_busy falls; cfg_active=1 for the whole wait.
REQ-037 req_valid=11 held, rates 01/11, rr_ptr=0 -> requester 0 acked first with baud_rate=01; requester 1 is then granted and acked with baud_rate=11; rr_ptr ends at 0.
REQ-038 reset_n=0 during SETTLE -> next edge baud_rate=10, gen_reset_n=0, req_ready=00, cfg_active=0; no ack thereafter.
REQ-039 Change req_rate and drop req_valid the cycle after grant -> latched rate is applied and req_ready is still pulsed.
